// File: rtl/lieat_exu_wbck_buf_if.sv
// lieat_exu_wbck_buf_if
// Bundles the three channels around the ALU result buffer:
//   exu_i_*  : ALU result handshake into the buffer (valid/ready)
//   wbck_o_* : head-of-buffer handshake towards the writeback port
//   fwd_*    : issue-stage operand lookup (index in, hit/data out)
// Modports:
//   master : the surroundings (ALU, writeback port, issue stage)
//   slave  : the buffer itself
interface lieat_exu_wbck_buf_if #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
);
  logic               exu_i_valid;
  logic               exu_i_ready;
  logic [XLEN-1:0]    exu_i_res;
  logic [REG_IDX-1:0] exu_i_rd;
  logic               exu_i_wen;
  logic [XLEN-1:0]    exu_i_pc;

  logic               wbck_o_valid;
  logic               wbck_o_ready;
  logic [XLEN-1:0]    wbck_o_res;
  logic [REG_IDX-1:0] wbck_o_rd;
  logic               wbck_o_wen;
  logic [XLEN-1:0]    wbck_o_pc;

  logic [REG_IDX-1:0] fwd_rs1_idx;
  logic               fwd_rs1_hit;
  logic [XLEN-1:0]    fwd_rs1_data;
  logic [REG_IDX-1:0] fwd_rs2_idx;
  logic               fwd_rs2_hit;
  logic [XLEN-1:0]    fwd_rs2_data;

  modport master (
    output exu_i_valid, exu_i_res, exu_i_rd, exu_i_wen, exu_i_pc,
    input  exu_i_ready,
    input  wbck_o_valid, wbck_o_res, wbck_o_rd, wbck_o_wen, wbck_o_pc,
    output wbck_o_ready,
    output fwd_rs1_idx, fwd_rs2_idx,
    input  fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data
  );

  modport slave (
    input  exu_i_valid, exu_i_res, exu_i_rd, exu_i_wen, exu_i_pc,
    output exu_i_ready,
    output wbck_o_valid, wbck_o_res, wbck_o_rd, wbck_o_wen, wbck_o_pc,
    input  wbck_o_ready,
    input  fwd_rs1_idx, fwd_rs2_idx,
    output fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data
  );
endinterface

// File: rtl/lieat_exu_wbck_buf.sv
// lieat_exu_wbck_buf
// In-order result buffer between the shared integer ALU and the writeback
// port. Completed results (res, rd, pc, effective wen) are queued in a
// DEPTH-entry FIFO and presented head-first to writeback. Buffered results
// are also forwarded combinationally to the issue stage (youngest match wins).
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset (beats flush)
//   flush   : drops every buffered entry and any same-cycle push/pop
//   bus     : exu_i / wbck_o / fwd channels (slave side)
//   buf_cnt : current occupancy, 0..DEPTH
module lieat_exu_wbck_buf #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5,
  parameter int DEPTH   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  lieat_exu_wbck_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0]     buf_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DEPTH-1:0]   ent_vld;

  logic [XLEN-1:0]    ent_res [DEPTH];
  logic [REG_IDX-1:0] ent_rd  [DEPTH];
  logic               ent_wen [DEPTH];
  logic [XLEN-1:0]    ent_pc  [DEPTH];

  logic               push;
  logic               pop;
  logic               not_empty;

  // Ready is purely a function of occupancy so a full buffer never accepts,
  // even when the head drains in the same cycle.
  assign bus.exu_i_ready = (cnt < CNT_W'(DEPTH));
  assign not_empty       = (cnt != '0);
  assign push            = bus.exu_i_valid & bus.exu_i_ready & ~flush;
  assign pop             = not_empty & bus.wbck_o_ready & ~flush;
  assign buf_cnt         = cnt;

  // Control state: pointers, count and per-entry valid bits.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      // push and pop never target the same slot: push needs non-full,
      // pop needs non-empty, and equal pointers imply one of the two.
      if (push && !pop)
        cnt <= cnt + CNT_W'(1);
      else if (pop && !push)
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry payload is qualified by ent_vld, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      ent_res[wr_ptr] <= bus.exu_i_res;
      ent_rd[wr_ptr]  <= bus.exu_i_rd;
      ent_wen[wr_ptr] <= bus.exu_i_wen & (bus.exu_i_rd != '0);
      ent_pc[wr_ptr]  <= bus.exu_i_pc;
    end
  end

  // Head presentation: fields are zeroed when nothing is buffered.
  always_comb begin
    bus.wbck_o_valid = not_empty;
    bus.wbck_o_res   = '0;
    bus.wbck_o_rd    = '0;
    bus.wbck_o_wen   = 1'b0;
    bus.wbck_o_pc    = '0;
    if (not_empty) begin
      bus.wbck_o_res = ent_res[rd_ptr];
      bus.wbck_o_rd  = ent_rd[rd_ptr];
      bus.wbck_o_wen = ent_wen[rd_ptr];
      bus.wbck_o_pc  = ent_pc[rd_ptr];
    end
  end

  // Forwarding: walk from the head (oldest) towards the write pointer so a
  // later match overrides an earlier one, leaving the youngest result.
  // The entry being popped this cycle is still valid and still searched.
  always_comb begin
    logic [PTR_W-1:0] idx;
    bus.fwd_rs1_hit  = 1'b0;
    bus.fwd_rs1_data = '0;
    bus.fwd_rs2_hit  = 1'b0;
    bus.fwd_rs2_data = '0;
    idx              = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (ent_vld[idx] && ent_wen[idx]) begin
        if ((bus.fwd_rs1_idx != '0) && (ent_rd[idx] == bus.fwd_rs1_idx)) begin
          bus.fwd_rs1_hit  = 1'b1;
          bus.fwd_rs1_data = ent_res[idx];
        end
        if ((bus.fwd_rs2_idx != '0) && (ent_rd[idx] == bus.fwd_rs2_idx)) begin
          bus.fwd_rs2_hit  = 1'b1;
          bus.fwd_rs2_data = ent_res[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_lieat_exu_wbck_buf.sv
module tb_lieat_exu_wbck_buf;
  localparam int XLEN    = 32;
  localparam int REG_IDX = 5;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] buf_cnt;

  lieat_exu_wbck_buf_if #(.XLEN(XLEN), .REG_IDX(REG_IDX)) bus ();

  lieat_exu_wbck_buf #(.XLEN(XLEN), .REG_IDX(REG_IDX), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus),
    .buf_cnt(buf_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of accepted results, oldest first.
  typedef struct {
    logic [XLEN-1:0]    res;
    logic [REG_IDX-1:0] rd;
    logic               wen;
    logic [XLEN-1:0]    pc;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic [31:0] rst, fl, v, res, rd, wen, pc, wr, rs1, rs2;
    logic [31:0] cnt, rdy, wv, wres, wrd, wwen, wpc, h1, d1, h2, d2;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [REG_IDX-1:0] idx, output logic hit,
                                 output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (idx != 0)
      foreach (mq[i])
        if (mq[i].wen && mq[i].rd == idx) begin
          hit = 1'b1;
          d   = mq[i].res;
        end
  endfunction

  task automatic check_model();
    logic h1, h2;
    logic [XLEN-1:0] d1, d2;
    bit ne;
    ne = (mq.size() != 0);
    lookup(bus.fwd_rs1_idx, h1, d1);
    lookup(bus.fwd_rs2_idx, h2, d2);
    chk("m_cnt",   64'(buf_cnt),          64'(mq.size()));
    chk("m_ready", 64'(bus.exu_i_ready),  64'(mq.size() < DEPTH));
    chk("m_valid", 64'(bus.wbck_o_valid), 64'(ne));
    chk("m_res",   64'(bus.wbck_o_res),   ne ? 64'(mq[0].res) : 64'(0));
    chk("m_rd",    64'(bus.wbck_o_rd),    ne ? 64'(mq[0].rd)  : 64'(0));
    chk("m_wen",   64'(bus.wbck_o_wen),   ne ? 64'(mq[0].wen) : 64'(0));
    chk("m_pc",    64'(bus.wbck_o_pc),    ne ? 64'(mq[0].pc)  : 64'(0));
    chk("m_hit1",  64'(bus.fwd_rs1_hit),  64'(h1));
    chk("m_data1", 64'(bus.fwd_rs1_data), 64'(d1));
    chk("m_hit2",  64'(bus.fwd_rs2_hit),  64'(h2));
    chk("m_data2", 64'(bus.fwd_rs2_data), 64'(d2));
  endtask

  // Decide push/pop from the spec rules, take the clock edge, update model.
  task automatic step_edge();
    bit do_push, do_pop, do_rst, do_fl;
    ent_t e;
    do_rst  = reset;
    do_fl   = flush;
    do_push = bus.exu_i_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = (mq.size() != 0) && bus.wbck_o_ready && !flush;
    e.res = bus.exu_i_res;
    e.rd  = bus.exu_i_rd;
    e.wen = bus.exu_i_wen && (bus.exu_i_rd != 0);
    e.pc  = bus.exu_i_pc;
    @(posedge clock);
    if (do_rst || do_fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input vec_t v);
    reset            = v.rst[0];
    flush            = v.fl[0];
    bus.exu_i_valid  = v.v[0];
    bus.exu_i_res    = v.res;
    bus.exu_i_rd     = v.rd[REG_IDX-1:0];
    bus.exu_i_wen    = v.wen[0];
    bus.exu_i_pc     = v.pc;
    bus.wbck_o_ready = v.wr[0];
    bus.fwd_rs1_idx  = v.rs1[REG_IDX-1:0];
    bus.fwd_rs2_idx  = v.rs2[REG_IDX-1:0];
  endtask

  task automatic check_vec(input int n, input vec_t v);
    string s;
    s = $sformatf("row%0d", n);
    chk({s, "_cnt"},   64'(buf_cnt),          64'(v.cnt));
    chk({s, "_ready"}, 64'(bus.exu_i_ready),  64'(v.rdy));
    chk({s, "_valid"}, 64'(bus.wbck_o_valid), 64'(v.wv));
    chk({s, "_res"},   64'(bus.wbck_o_res),   64'(v.wres));
    chk({s, "_rd"},    64'(bus.wbck_o_rd),    64'(v.wrd));
    chk({s, "_wen"},   64'(bus.wbck_o_wen),   64'(v.wwen));
    chk({s, "_pc"},    64'(bus.wbck_o_pc),    64'(v.wpc));
    chk({s, "_hit1"},  64'(bus.fwd_rs1_hit),  64'(v.h1));
    chk({s, "_data1"}, 64'(bus.fwd_rs1_data), 64'(v.d1));
    chk({s, "_hit2"},  64'(bus.fwd_rs2_hit),  64'(v.h2));
    chk({s, "_data2"}, 64'(bus.fwd_rs2_data), 64'(v.d2));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(tbl[i]);
      @(negedge clock);
      check_vec(i, tbl[i]);
      check_model();
      step_edge();
    end
  endtask

  initial begin
    vec_t idle;
    idle = '{default: 0};
    //           rst fl v  res       rd wen pc           wr rs1 rs2  cnt rdy wv wres     wrd wwen wpc          h1 d1       h2 d2
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 0,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{0, 0, 1, 'h1234,   5, 1, 'h80000000,  0, 5,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{0, 0, 1, 'h5678,   6, 1, 'h80000004,  0, 5,  6,   1,  1,  1, 'h1234,  5,  1,   'h80000000,  1, 'h1234,  0, 0});
    tbl.push_back('{0, 0, 1, 'h9999,   7, 1, 'h80000008,  0, 5,  6,   2,  0,  1, 'h1234,  5,  1,   'h80000000,  1, 'h1234,  1, 'h5678});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 7,  6,   2,  0,  1, 'h1234,  5,  1,   'h80000000,  0, 0,       1, 'h5678});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 5,  6,   1,  1,  1, 'h5678,  6,  1,   'h80000004,  0, 0,       1, 'h5678});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 0,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    // forwarding: youngest match, rd=x0 handling
    tbl.push_back('{0, 0, 1, 'hA,      7, 1, 'h100,       0, 7,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{0, 0, 1, 'hB,      7, 1, 'h104,       0, 7,  0,   1,  1,  1, 'hA,     7,  1,   'h100,       1, 'hA,     0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 7,  0,   2,  0,  1, 'hA,     7,  1,   'h100,       1, 'hB,     0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 7,  0,   2,  0,  1, 'hA,     7,  1,   'h100,       1, 'hB,     0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 7,  0,   1,  1,  1, 'hB,     7,  1,   'h104,       1, 'hB,     0, 0});
    tbl.push_back('{0, 0, 1, 'hC,      0, 1, 'h108,       0, 0,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 0,  0,   1,  1,  1, 'hC,     0,  0,   'h108,       0, 0,       0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 0,  0,   1,  1,  1, 'hC,     0,  0,   'h108,       0, 0,       0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 0,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    // flush with simultaneous push and pop
    tbl.push_back('{0, 0, 1, 'h11,     1, 1, 'h200,       0, 2,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{0, 0, 1, 'h22,     2, 1, 'h204,       0, 2,  0,   1,  1,  1, 'h11,    1,  1,   'h200,       0, 0,       0, 0});
    tbl.push_back('{0, 1, 1, 'h33,     3, 1, 'h208,       1, 2,  1,   2,  0,  1, 'h11,    1,  1,   'h200,       1, 'h22,    1, 'h11});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           1, 2,  3,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    // reset mid-stream with a same-cycle push
    tbl.push_back('{0, 0, 1, 'h44,     4, 1, 'h300,       0, 4,  0,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});
    tbl.push_back('{1, 0, 1, 'h55,     5, 1, 'h304,       0, 4,  5,   1,  1,  1, 'h44,    4,  1,   'h300,       1, 'h44,    0, 0});
    tbl.push_back('{0, 0, 0, 0,        0, 0, 0,           0, 4,  5,   0,  1,  0, 0,       0,  0,   0,           0, 0,       0, 0});

    idle.rst = 1;
    drive(idle);
    @(posedge clock);
    @(posedge clock);
    #1;
    mq.delete();

    run_rows(0, 7);

    // Continuous push+pop: one entry primed, then 8 cycles of push and pop.
    for (int i = 0; i <= 8; i++) begin
      vec_t v;
      v = '{default: 0};
      v.v = 1; v.res = 32'h100 + i; v.rd = (i % 3) + 1; v.wen = 1;
      v.pc = 32'h1000 + 4 * i; v.wr = 1;
      drive(v);
      @(negedge clock);
      if (i > 0) begin
        chk($sformatf("stream%0d_cnt", i), 64'(buf_cnt), 64'(1));
        chk($sformatf("stream%0d_res", i), 64'(bus.wbck_o_res), 64'(32'h100 + i - 1));
        chk($sformatf("stream%0d_pc", i),  64'(bus.wbck_o_pc),  64'(32'h1000 + 4 * (i - 1)));
      end
      check_model();
      step_edge();
    end
    idle = '{default: 0};
    idle.wr = 1;
    drive(idle);
    @(negedge clock);
    chk("stream_last_res", 64'(bus.wbck_o_res), 64'(32'h108));
    check_model();
    step_edge();

    run_rows(7, tbl.size());

    // Randomized traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      vec_t v;
      v = '{default: 0};
      v.rst = ($urandom_range(0, 49) == 0);
      v.fl  = ($urandom_range(0, 19) == 0);
      v.v   = ($urandom_range(0, 3) != 0);
      v.res = $urandom;
      v.rd  = $urandom_range(0, 3);
      v.wen = ($urandom_range(0, 3) != 0);
      v.pc  = $urandom;
      v.wr  = $urandom_range(0, 1);
      v.rs1 = $urandom_range(0, 3);
      v.rs2 = $urandom_range(0, 3);
      drive(v);
      @(negedge clock);
      check_model();
      step_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lieat_exu_wbck_buf.md
Name: lieat_exu_wbck_buf

Overview:
Result buffer directly downstream of the shared integer ALU. It captures each completed ALU result together with its destination register index and PC, then holds it in a small in-order FIFO until the writeback port accepts it. It also provides combinational operand forwarding from buffered results back to the issue stage, and supports a pipeline flush.

Parameters:
XLEN, 32, datapath width of result and PC
REG_IDX, 5, register index width
DEPTH, 2, number of buffer entries (power of two, >= 2)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries and any same-cycle input
exu_i_valid  in  1  ALU result valid
exu_i_ready  out  1  buffer can accept a result
exu_i_res  in  XLEN  ALU result (com_req_res)
exu_i_rd  in  REG_IDX  destination register index
exu_i_wen  in  1  result is to be written to the register file
exu_i_pc  in  XLEN  PC of the producing instruction
wbck_o_valid  out  1  head entry valid
wbck_o_ready  in  1  writeback accepts head entry
wbck_o_res  out  XLEN  head result
wbck_o_rd  out  REG_IDX  head destination index
wbck_o_wen  out  1  head write enable
wbck_o_pc  out  XLEN  head PC
fwd_rs1_idx  in  REG_IDX  issue-stage source 1 index
fwd_rs1_hit  out  1  source 1 matches a buffered entry
fwd_rs1_data  out  XLEN  forwarded source 1 value
fwd_rs2_idx  in  REG_IDX  issue-stage source 2 index
fwd_rs2_hit  out  1  source 2 matches a buffered entry
fwd_rs2_data  out  XLEN  forwarded source 2 value
buf_cnt  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (clock edge with reset=1): read/write pointers and count cleared to 0. All entry valid bits cleared. wbck_o_valid=0, buf_cnt=0, exu_i_ready=1, all hit outputs 0.
- When an output is not valid, its data outputs (wbck_o_res/rd/wen/pc, fwd_*_data) are driven to 0.
- Push: occurs when exu_i_valid & exu_i_ready & ~flush. exu_i_ready = (count < DEPTH). It depends only on state, never on wbck_o_ready.
- Push stores res, rd, pc and wen_eff = exu_i_wen & (exu_i_rd != 0). An entry with rd=x0 is still buffered and written back with wen=0.
- Pop: occurs when wbck_o_valid & wbck_o_ready & ~flush. wbck_o_valid = (count != 0). Head fields come directly from the entry registers.
- Latency: a push at edge N is visible on wbck_o_* in cycle N+1. There is no combinational input-to-output path.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, push is impossible (ready=0) even if a pop occurs in the same cycle. When empty, a pop is impossible.
- Pointers wrap modulo DEPTH. Count is bounded to [0, DEPTH].
- Ordering: strictly FIFO, and writeback order equals push order.
- Flush=1 at an edge: count, pointers and all valid bits go to 0. Any push or pop in that cycle is ignored. Flush takes priority over everything except reset. Reset takes priority over flush.
- Forwarding (combinational):
  - fwd_rsN_hit = 1 iff fwd_rsN_idx != 0 and some valid entry has wen=1 and rd == fwd_rsN_idx.
  - fwd_rsN_data is the res of the youngest matching entry, i.e. the one closest to the write pointer.
  - The incoming exu_i_* is not forwarded by this block.
  - An entry being popped in the current cycle still participates in forwarding during that cycle.
- The issue stage must use fwd data on hit and the register file otherwise. The register-file write occurs on pop.

Test Plan:
- Reset then idle -> wbck_o_valid=0, exu_i_ready=1, buf_cnt=0, hits=0, all data outputs 0.
- Push {res=0x1234, rd=5, wen=1, pc=0x80000000} with wbck_o_ready=0 -> next cycle wbck_o_valid=1 with same fields and buf_cnt=1. Then push rd=6 -> buf_cnt=2, exu_i_ready=0. A third push attempt is not accepted.
- Buffer full, raise wbck_o_ready for 2 cycles -> pops in order rd=5 then rd=6, buf_cnt 2->1->0. Then run continuous push+pop for 8 cycles -> buf_cnt stays 1, 8 results emerge in order, pointers wrap.
- Push rd=7 res=0xA, then push rd=7 res=0xB; set fwd_rs1_idx=7, fwd_rs2_idx=0 -> rs1_hit=1 with data 0xB, rs2_hit=0. Push rd=0 wen=1 -> stored wen=0 and no hit for idx 0.
- Two entries buffered, assert flush together with exu_i_valid=1 and wbck_o_ready=1 -> next cycle buf_cnt=0, wbck_o_valid=0, no pop observed, input dropped.
- Assert reset mid-stream with 1 entry buffered and a push in the same cycle -> next cycle buffer is empty and ready=1.
